// File: rtl/systolic_skew_buffer_pkg.sv
// Shared types and helpers for the systolic skew/deskew buffer.
//   SKEW_MODE_TYPE  : SKEW delays lane i by i steps, DESKEW by (width-1-i) steps
//   SKEW_STATE_TYPE : controller states
//   tap_width()     : bits needed to select taps 0..depth (minimum 1)
//   lane_delay()    : per-lane delay in advance steps for a given mode
package systolic_skew_buffer_pkg;

   typedef enum logic {
      SKEW   = 1'b0,
      DESKEW = 1'b1
   } SKEW_MODE_TYPE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } SKEW_STATE_TYPE;

   typedef logic [7:0] BYTE_TYPE;

   function automatic int tap_width(input int depth);
      return (depth > 0) ? $clog2(depth + 1) : 1;
   endfunction

   function automatic int lane_delay(input SKEW_MODE_TYPE m, input int lane, input int width);
      return (m == SKEW) ? lane : (width - 1 - lane);
   endfunction

endpackage

// File: rtl/systolic_lane_delay.sv
// One lane of the skew buffer: a {valid, data} shift chain of DEPTH stages that
// moves only on advance, with a runtime tap select. Tap 0 is the combinational
// injected cell, tap k is the cell injected k advance steps ago.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears the chain)
//   advance        : shift enable; output is forced invalid when low
//   in_valid       : inject a valid element this step (otherwise a {0,0} bubble)
//   in_data        : element to inject
//   tap            : selected delay 0..DEPTH
//   out_valid      : selected cell is valid and the chain is advancing
//   out_data       : selected data, zero when out_valid is low
module systolic_lane_delay
   import systolic_skew_buffer_pkg::*;
#(
   parameter int DEPTH      = 13,
   parameter int DATA_WIDTH = 8,
   parameter int TAP_W      = tap_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [TAP_W-1:0]      tap,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef struct packed {
      logic  v;
      data_t d;
   } cell_t;

   cell_t inject;
   cell_t sel;

   // Invalid elements never carry data, so bubbles and drain cycles inject zero.
   always_comb begin
      inject.v = in_valid;
      inject.d = in_valid ? in_data : '0;
   end

   if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst, tap};
      assign sel = inject;
   end else begin : g_chain
      cell_t [DEPTH-1:0] stage_q;
      cell_t [DEPTH-1:0] stage_d;

      always_comb begin
         stage_d = stage_q;
         if (advance) begin
            stage_d[0] = inject;
            for (int k = 1; k < DEPTH; k++) begin
               stage_d[k] = stage_q[k-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            stage_q <= '0;
         end else begin
            stage_q <= stage_d;
         end
      end

      always_comb begin
         sel = inject;
         for (int k = 0; k < DEPTH; k++) begin
            if (tap == TAP_W'(k + 1)) begin
               sel = stage_q[k];
            end
         end
      end
   end

   assign out_valid = advance & sel.v;
   assign out_data  = out_valid ? sel.d : '0;

endmodule

// File: rtl/systolic_skew_buffer.sv
// Skews a row-parallel vector stream into a diagonal wavefront (SKEW) or
// realigns a wavefront into rows (DESKEW), with a valid/ready input handshake
// and an automatic drain that flushes the burst tail after in_last.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   mode             : 0 = SKEW, 1 = DESKEW; captured on the first beat of a burst
//   in_valid/ready   : input row handshake
//   in_last          : final row of the burst
//   data_input       : row vector, lane 0 in element [0]
//   systolic_output  : skewed/deskewed vector, zero on invalid lanes
//   lane_valid       : per-lane valid
//   out_valid        : any lane valid
//   out_last         : final element of the burst is on the output
//   busy             : controller not idle
//
// state  | meaning
// IDLE   | waiting for the first beat of a burst; mode follows the input pin
// STREAM | burst open, accepting rows with the latched mode
// DRAIN  | in_ready low, injecting bubbles for MATRIX_WIDTH-1 steps
module systolic_skew_buffer
   import systolic_skew_buffer_pkg::*;
#(
   parameter int MATRIX_WIDTH = 14,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    mode,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic                                    in_last,
   input  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] data_input,
   output logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] systolic_output,
   output logic [MATRIX_WIDTH-1:0]                 lane_valid,
   output logic                                    out_valid,
   output logic                                    out_last,
   output logic                                    busy
);

   localparam int DEPTH      = MATRIX_WIDTH - 1;
   localparam int TAP_W      = tap_width(DEPTH);
   localparam int CNT_W      = (MATRIX_WIDTH > 2) ? $clog2(MATRIX_WIDTH - 1) : 1;
   localparam int DRAIN_LOAD = (MATRIX_WIDTH > 1) ? MATRIX_WIDTH - 2 : 0;

   SKEW_STATE_TYPE state_q, state_d;
   SKEW_MODE_TYPE  mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic          accept;
   logic          advance;
   SKEW_MODE_TYPE mode_eff;

   assign in_ready = (state_q != DRAIN);
   assign accept   = in_valid & in_ready;
   assign advance  = accept | (state_q == DRAIN);
   assign busy     = (state_q != IDLE);

   // The first beat of a burst already needs its delays, so in IDLE the pin is
   // used directly rather than waiting for the latched copy.
   assign mode_eff = (state_q == IDLE) ? SKEW_MODE_TYPE'(mode) : mode_q;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      out_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d = SKEW_MODE_TYPE'(mode);
               if (in_last) begin
                  if (MATRIX_WIDTH == 1) begin
                     state_d  = IDLE;
                     out_last = 1'b1;
                  end else begin
                     state_d = DRAIN;
                     cnt_d   = CNT_W'(DRAIN_LOAD);
                  end
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept && in_last) begin
               if (MATRIX_WIDTH == 1) begin
                  state_d  = IDLE;
                  out_last = 1'b1;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = CNT_W'(DRAIN_LOAD);
               end
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d  = IDLE;
               out_last = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= SKEW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
      logic [TAP_W-1:0] tap;
      assign tap = TAP_W'(lane_delay(mode_eff, i, MATRIX_WIDTH));

      systolic_lane_delay #(
         .DEPTH      (DEPTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .advance   (advance),
         .in_valid  (accept),
         .in_data   (data_input[i]),
         .tap       (tap),
         .out_valid (lane_valid[i]),
         .out_data  (systolic_output[i])
      );
   end

   assign out_valid = |lane_valid;

endmodule
